// File: rtl/pll_reset_sequencer.sv
// Sequences the DDR3 clocking PLL: reset pulse, lock wait with timeout/retry, lock
// qualification, staggered per-domain reset release and teardown on lock loss.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned N_DOMAINS      = 4,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                 clk_in1,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 retry_req,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 fail,
  output logic [7:0]           lock_loss_count
);

  localparam int unsigned RelCycles = N_DOMAINS * STAGGER_CYCLES;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCnt = max_of(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                                 max_of(STABLE_CYCLES, RelCycles)),
                                          max_of(STAGGER_CYCLES, MAX_RETRIES));
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES) + 1;

  typedef enum logic [2:0] {
    StPllRst, StWaitLock, StStable, StRelease, StRun, StFail
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic                   sync1_q, lock_s;
  logic                   pll_rst_q, pll_rst_d;
  logic [N_DOMAINS-1:0]   domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic [7:0]             loss_cnt_q, loss_cnt_d;
  logic                   lost;

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lock_s  <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    domain_rst_d = domain_rst_q;
    lost         = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RetryW'(MAX_RETRIES)) ? StFail : StPllRst;
        end
      end
      StStable: begin
        if (!lock_s) state_d = StWaitLock;
        else if (cnt_q == CntW'(STABLE_CYCLES - 1)) state_d = StRelease;
      end
      StRelease: begin
        // Lock loss wins over any release due on the same edge.
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = StPllRst;
        end else begin
          for (int unsigned i = 0; i < N_DOMAINS; i++) begin
            if (cnt_q == CntW'((i + 1) * STAGGER_CYCLES - 1)) domain_rst_d[i] = 1'b0;
          end
          if (cnt_q == CntW'(RelCycles - 1)) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
      end
      StRun: begin
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = StPllRst;
        end
      end
      StFail: begin
        if (retry_req) begin
          retry_d = '0;
          state_d = StPllRst;
        end
      end
      default: state_d = StPllRst;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (state_q == StRun || state_q == StFail) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;

    // Outputs are registered from the next state so they line up with state_q.
    pll_rst_d = (state_d == StPllRst) || (state_d == StFail);
    ready_d   = (state_d == StRun);
    fail_d    = (state_d == StFail);
    if (state_d == StRun) domain_rst_d = '0;
    else if (state_d != StRelease) domain_rst_d = '1;

    loss_cnt_d = loss_cnt_q;
    if (lost && loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q      <= StPllRst;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign domain_rst      = domain_rst_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters; expected
// waveforms are hand-derived cycle tables indexed from reset release.
module tb_pll_reset_sequencer;

  logic       clk_in1 = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       retry_req;
  logic       pll_rst;
  logic [3:0] domain_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .STAGGER_CYCLES(3),
    .N_DOMAINS     (4),
    .MAX_RETRIES   (3)
  ) dut (
    .clk_in1        (clk_in1),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .retry_req      (retry_req),
    .pll_rst        (pll_rst),
    .domain_rst     (domain_rst),
    .ready          (ready),
    .fail           (fail),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic step(input int n);
    repeat (n) @(negedge clk_in1);
  endtask

  // Leaves reset deasserted at a falling edge: that instant is cycle 0.
  task automatic do_reset(input logic lock);
    reset      = 1'b1;
    pll_locked = lock;
    retry_req  = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
    step(2);
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset pll_rst got %b want 1", pll_rst); end
    n_tests++; if (domain_rst !== 4'b1111) begin n_fail++; $display("FAIL reset domain_rst got %b want 1111", domain_rst); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset ready got %b want 0", ready); end
    n_tests++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset fail got %b want 0", fail); end
    n_tests++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL reset count got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_bringup;
    logic e_pll, e_rdy; logic [3:0] e_dom;
    do_reset(1'b0);
    for (int k = 0; k <= 33; k++) begin
      if (k == 8) pll_locked = 1'b1;
      e_pll = (k < 4);
      e_dom = (k < 22) ? 4'b1111 : (k < 25) ? 4'b1110 : (k < 28) ? 4'b1100 :
              (k < 31) ? 4'b1000 : 4'b0000;
      e_rdy = (k >= 31);
      n_tests++; if (pll_rst !== e_pll) begin n_fail++; $display("FAIL bringup pll_rst cyc %0d got %b want %b", k, pll_rst, e_pll); end
      n_tests++; if (domain_rst !== e_dom) begin n_fail++; $display("FAIL bringup domain_rst cyc %0d got %b want %b", k, domain_rst, e_dom); end
      n_tests++; if (ready !== e_rdy) begin n_fail++; $display("FAIL bringup ready cyc %0d got %b want %b", k, ready, e_rdy); end
      step(1);
    end
  endtask

  task automatic test_timeout;
    logic e_pll, e_fail;
    do_reset(1'b0);
    for (int k = 0; k <= 160; k++) begin
      if (k == 80) retry_req = 1'b1;
      if (k == 81) retry_req = 1'b0;
      e_pll = (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52) || (k >= 72 && k < 85) ||
              (k >= 105 && k < 109) || (k >= 129 && k < 133) || (k >= 153);
      e_fail = (k >= 72 && k < 81) || (k >= 153);
      n_tests++; if (pll_rst !== e_pll) begin n_fail++; $display("FAIL timeout pll_rst cyc %0d got %b want %b", k, pll_rst, e_pll); end
      n_tests++; if (fail !== e_fail) begin n_fail++; $display("FAIL timeout fail cyc %0d got %b want %b", k, fail, e_fail); end
      n_tests++; if (domain_rst !== 4'b1111 || ready !== 1'b0) begin
        n_fail++; $display("FAIL timeout dom/ready cyc %0d got %b/%b want 1111/0", k, domain_rst, ready);
      end
      step(1);
    end
  endtask

  task automatic test_glitch;
    logic e_pll, e_rdy; logic [3:0] e_dom;
    do_reset(1'b0);
    for (int k = 0; k <= 41; k++) begin
      if (k == 8)  pll_locked = 1'b1;
      if (k == 15) pll_locked = 1'b0;
      if (k == 16) pll_locked = 1'b1;
      e_pll = (k < 4);
      e_dom = (k < 30) ? 4'b1111 : (k < 33) ? 4'b1110 : (k < 36) ? 4'b1100 :
              (k < 39) ? 4'b1000 : 4'b0000;
      e_rdy = (k >= 39);
      n_tests++; if (pll_rst !== e_pll) begin n_fail++; $display("FAIL glitch pll_rst cyc %0d got %b want %b", k, pll_rst, e_pll); end
      n_tests++; if (domain_rst !== e_dom) begin n_fail++; $display("FAIL glitch domain_rst cyc %0d got %b want %b", k, domain_rst, e_dom); end
      n_tests++; if (ready !== e_rdy) begin n_fail++; $display("FAIL glitch ready cyc %0d got %b want %b", k, ready, e_rdy); end
      n_tests++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL glitch count cyc %0d got %0d want 0", k, lock_loss_count); end
      step(1);
    end
  endtask

  task automatic test_lock_loss_run;
    logic e_pll, e_rdy; logic [3:0] e_dom; logic [7:0] e_cnt;
    do_reset(1'b1);
    for (int k = 0; k <= 60; k++) begin
      if (k == 27) pll_locked = 1'b0;
      if (k == 30) pll_locked = 1'b1;
      e_pll = (k < 4) || (k >= 30 && k < 34);
      e_dom = (k < 16) ? 4'b1111 : (k < 19) ? 4'b1110 : (k < 22) ? 4'b1100 :
              (k < 25) ? 4'b1000 : (k < 30) ? 4'b0000 : (k < 46) ? 4'b1111 :
              (k < 49) ? 4'b1110 : (k < 52) ? 4'b1100 : (k < 55) ? 4'b1000 : 4'b0000;
      e_rdy = (k >= 25 && k < 30) || (k >= 55);
      e_cnt = (k >= 30) ? 8'd1 : 8'd0;
      n_tests++; if (pll_rst !== e_pll) begin n_fail++; $display("FAIL runloss pll_rst cyc %0d got %b want %b", k, pll_rst, e_pll); end
      n_tests++; if (domain_rst !== e_dom) begin n_fail++; $display("FAIL runloss domain_rst cyc %0d got %b want %b", k, domain_rst, e_dom); end
      n_tests++; if (ready !== e_rdy) begin n_fail++; $display("FAIL runloss ready cyc %0d got %b want %b", k, ready, e_rdy); end
      n_tests++; if (lock_loss_count !== e_cnt) begin n_fail++; $display("FAIL runloss count cyc %0d got %0d want %0d", k, lock_loss_count, e_cnt); end
      step(1);
    end
  endtask

  task automatic test_release_loss_saturate;
    logic [7:0] e_cnt;
    do_reset(1'b1);
    step(16);
    n_tests++; if (domain_rst !== 4'b1110) begin n_fail++; $display("FAIL relloss dom0 got %b want 1110", domain_rst); end
    pll_locked = 1'b0;
    step(2);
    n_tests++; if (domain_rst !== 4'b1110) begin n_fail++; $display("FAIL relloss pre got %b want 1110", domain_rst); end
    step(1);
    n_tests++; if (domain_rst !== 4'b1111 || pll_rst !== 1'b1 || ready !== 1'b0) begin
      n_fail++; $display("FAIL relloss teardown got dom %b pll %b rdy %b want 1111 1 0", domain_rst, pll_rst, ready);
    end
    n_tests++; if (lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL relloss count got %0d want 1", lock_loss_count); end
    for (int n = 2; n <= 256; n++) begin
      pll_locked = 1'b1;
      step(16);
      n_tests++; if (domain_rst !== 4'b1110) begin n_fail++; $display("FAIL satloop dom0 loss %0d got %b want 1110", n, domain_rst); end
      pll_locked = 1'b0;
      step(3);
      e_cnt = (n > 255) ? 8'd255 : 8'(n);
      n_tests++; if (domain_rst !== 4'b1111 || lock_loss_count !== e_cnt) begin
        n_fail++; $display("FAIL satloop loss %0d got dom %b cnt %0d want 1111 %0d", n, domain_rst, lock_loss_count, e_cnt);
      end
    end
  endtask

  task automatic test_async_spurious;
    do_reset(1'b1);
    step(25);
    n_tests++; if (ready !== 1'b1 || domain_rst !== 4'b0000) begin
      n_fail++; $display("FAIL spur run got rdy %b dom %b want 1 0000", ready, domain_rst);
    end
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    step(2);
    n_tests++; if (ready !== 1'b1 || fail !== 1'b0 || pll_rst !== 1'b0 || domain_rst !== 4'b0000) begin
      n_fail++; $display("FAIL spur retry got rdy %b fail %b pll %b dom %b want 1 0 0 0000", ready, fail, pll_rst, domain_rst);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (pll_rst !== 1'b1 || domain_rst !== 4'b1111 || ready !== 1'b0 || fail !== 1'b0) begin
      n_fail++; $display("FAIL async got pll %b dom %b rdy %b fail %b want 1 1111 0 0", pll_rst, domain_rst, ready, fail);
    end
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_glitch();
    test_lock_loss_run();
    test_release_loss_saturate();
    test_async_spurious();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
